// File: rtl/alu_pkg.sv
// Shared ALU encodings: 5-bit ALUop values, MIPS opcode/funct/regimm constants
// and the decoded request record carried through the issue buffer.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] ALUOP_ADD    = 5'b00000;
  localparam logic [4:0] ALUOP_SUB    = 5'b00001;
  localparam logic [4:0] ALUOP_SLT    = 5'b01000;
  localparam logic [4:0] ALUOP_SLTU   = 5'b01001;
  localparam logic [4:0] ALUOP_SNE    = 5'b01010;
  localparam logic [4:0] ALUOP_SE     = 5'b01011;
  localparam logic [4:0] ALUOP_SGE    = 5'b01100;
  localparam logic [4:0] ALUOP_SGEU   = 5'b01101;
  localparam logic [4:0] ALUOP_SLL    = 5'b10000;
  localparam logic [4:0] ALUOP_SRL    = 5'b10001;
  localparam logic [4:0] ALUOP_SRA    = 5'b10010;
  localparam logic [4:0] ALUOP_AND    = 5'b10100;
  localparam logic [4:0] ALUOP_OR     = 5'b10101;
  localparam logic [4:0] ALUOP_XOR    = 5'b10110;
  localparam logic [4:0] ALUOP_NOR    = 5'b10111;
  localparam logic [4:0] ALUOP_BYPASS = 5'b11000;
  localparam logic [4:0] ALUOP_JLINK  = 5'b11001;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [4:0] REGIMM_BLTZ = 5'd0;
  localparam logic [4:0] REGIMM_BGEZ = 5'd1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        aluop;
    logic              illegal;
  } alu_req_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: instruction plus rs/rt/pc values -> ALU operands and ALUop.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter logic [4:0] ILL_OP = 5'b11000
) (
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [DATA_W-1:0] pc,
  output alu_req_t          req
);

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rt_field;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_shamt;
  logic              w_unused_rs_field;
  logic              w_hit;

  assign w_op              = inst[31:26];
  assign w_funct           = inst[5:0];
  assign w_rt_field        = inst[20:16];
  assign w_sext            = {{16{inst[15]}}, inst[15:0]};
  assign w_zext            = {16'b0, inst[15:0]};
  assign w_shamt           = {27'b0, inst[10:6]};
  // Operand values arrive already read from the register file; the rs index itself is not needed.
  assign w_unused_rs_field = ^inst[25:21];

  always_comb begin
    req.a       = rs;
    req.b       = '0;
    req.aluop   = ILL_OP;
    req.illegal = 1'b0;
    w_hit       = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FUNCT_ADDU: begin req.aluop = ALUOP_ADD;  req.b = rt; end
          FUNCT_SUBU: begin req.aluop = ALUOP_SUB;  req.b = rt; end
          FUNCT_AND:  begin req.aluop = ALUOP_AND;  req.b = rt; end
          FUNCT_OR:   begin req.aluop = ALUOP_OR;   req.b = rt; end
          FUNCT_XOR:  begin req.aluop = ALUOP_XOR;  req.b = rt; end
          FUNCT_NOR:  begin req.aluop = ALUOP_NOR;  req.b = rt; end
          FUNCT_SLT:  begin req.aluop = ALUOP_SLT;  req.b = rt; end
          FUNCT_SLTU: begin req.aluop = ALUOP_SLTU; req.b = rt; end
          FUNCT_SLL:  begin req.aluop = ALUOP_SLL;  req.a = rt; req.b = w_shamt; end
          FUNCT_SRL:  begin req.aluop = ALUOP_SRL;  req.a = rt; req.b = w_shamt; end
          FUNCT_SRA:  begin req.aluop = ALUOP_SRA;  req.a = rt; req.b = w_shamt; end
          FUNCT_SLLV: begin req.aluop = ALUOP_SLL;  req.a = rt; req.b = rs; end
          FUNCT_SRLV: begin req.aluop = ALUOP_SRL;  req.a = rt; req.b = rs; end
          FUNCT_SRAV: begin req.aluop = ALUOP_SRA;  req.a = rt; req.b = rs; end
          FUNCT_JALR: begin req.aluop = ALUOP_JLINK; req.a = pc; end
          default:    w_hit = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: begin req.aluop = ALUOP_ADD;  req.b = w_sext; end
      OP_SLTI:  begin req.aluop = ALUOP_SLT;    req.b = w_sext; end
      OP_SLTIU: begin req.aluop = ALUOP_SLTU;   req.b = w_sext; end
      OP_ANDI:  begin req.aluop = ALUOP_AND;    req.b = w_zext; end
      OP_ORI:   begin req.aluop = ALUOP_OR;     req.b = w_zext; end
      OP_XORI:  begin req.aluop = ALUOP_XOR;    req.b = w_zext; end
      OP_LUI:   begin req.aluop = ALUOP_BYPASS; req.b = {inst[15:0], 16'b0}; end
      OP_JAL:   begin req.aluop = ALUOP_JLINK;  req.a = pc; end
      OP_BEQ:   begin req.aluop = ALUOP_SE;     req.b = rt; end
      OP_BNE:   begin req.aluop = ALUOP_SNE;    req.b = rt; end
      // blez/bgtz compare zero against rs, so rs moves to the B side.
      OP_BLEZ:  begin req.aluop = ALUOP_SGE;    req.a = '0; req.b = rs; end
      OP_BGTZ:  begin req.aluop = ALUOP_SLT;    req.a = '0; req.b = rs; end
      OP_REGIMM: begin
        case (w_rt_field)
          REGIMM_BLTZ: req.aluop = ALUOP_SLT;
          REGIMM_BGEZ: req.aluop = ALUOP_SGE;
          default:     w_hit = 1'b0;
        endcase
      end
      default: w_hit = 1'b0;
    endcase
    if (!w_hit) begin
      req.a       = rs;
      req.b       = '0;
      req.aluop   = ILL_OP;
      req.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// ALU operand issue stage: decodes at the input and holds decoded requests in a
// valid/ready elastic buffer (DEPTH=2 skid keeps in_ready a pure register output).
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int         DEPTH  = 2,
  parameter logic [4:0] ILL_OP = 5'b11000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_aluop,
  output logic              out_illegal
);

  alu_req_t w_req;
  alu_req_t r_ent0_p1;
  alu_req_t r_ent1_p1;
  logic     r_vld0_p1;
  logic     r_vld1_p1;
  logic     w_push;
  logic     w_pop;

  alu_op_decode #(.ILL_OP(ILL_OP)) u_decode (
    .inst (in_inst),
    .rs   (in_rs),
    .rt   (in_rt),
    .pc   (in_pc),
    .req  (w_req)
  );

  assign in_ready = (DEPTH == 1) ? (~r_vld0_p1 | out_ready) : ~r_vld1_p1;
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = r_vld0_p1 & out_ready;

  // ---- decode -> buffer entry boundary ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld0_p1 <= 1'b0;
      r_vld1_p1 <= 1'b0;
      r_ent0_p1 <= '0;
      r_ent1_p1 <= '0;
    end else if (flush) begin
      r_vld0_p1 <= 1'b0;
      r_vld1_p1 <= 1'b0;
    end else if (w_pop) begin
      if (r_vld1_p1) begin
        r_ent0_p1 <= r_ent1_p1;
        if (w_push) r_ent1_p1 <= w_req;
        else        r_vld1_p1 <= 1'b0;
      end else if (w_push) begin
        r_ent0_p1 <= w_req;
      end else begin
        r_vld0_p1 <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_vld0_p1) begin
        r_ent0_p1 <= w_req;
        r_vld0_p1 <= 1'b1;
      end else begin
        r_ent1_p1 <= w_req;
        r_vld1_p1 <= 1'b1;
      end
    end
  end

  assign out_valid   = r_vld0_p1;
  assign out_a       = r_ent0_p1.a;
  assign out_b       = r_ent0_p1.b;
  assign out_aluop   = r_ent0_p1.aluop;
  assign out_illegal = r_ent0_p1.illegal;

endmodule
